// File: rtl/decode.sv
// NRZI decoder for the USB receive path: compares the current line sample
// against the line level captured at the previous bit-centre strobe.
module decode (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic shift_enable,
  input  logic eop,
  output logic d_orig
);

  logic cur_bit;
  logic prev_bit;

  // Sample the raw line every clock; reset to the idle (J) level.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cur_bit <= 1'b1;
    end else begin
      cur_bit <= d_plus;
    end
  end

  // Capture the bit reference on each strobe; at end of packet, force idle
  // so the first bit of the next packet decodes against J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_bit <= 1'b1;
    end else if (shift_enable) begin
      prev_bit <= eop ? 1'b1 : d_plus;
    end
  end

  // Unchanged level decodes as 1, a transition as 0.
  always_comb begin
    d_orig = ~(cur_bit ^ prev_bit);
  end

endmodule

// File: tb/tb_decode.sv
// Directed bench for the NRZI decoder: drives on the falling edge and checks
// d_orig on the falling edge, i.e. during the cycle a strobe is presented.
module tb_decode;

  logic clk;
  logic n_rst;
  logic d_plus;
  logic shift_enable;
  logic eop;
  logic d_orig;

  int checks;
  int errors;
  logic lvl;

  decode dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus       (d_plus),
    .shift_enable (shift_enable),
    .eop          (eop),
    .d_orig       (d_orig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8-clock bit period with the line at level l and the strobe at
  // clock 4; d_orig is checked while the strobe is high.
  task automatic bit_period(input logic l, input logic exp, input string tag);
    d_plus = l;
    ticks(4);
    check(d_orig, exp, tag);
    shift_enable = 1'b1;
    ticks(1);
    shift_enable = 1'b0;
    ticks(3);
  endtask

  // NRZI-encode a byte LSB first from the current level: 0 toggles, 1 holds.
  task automatic send_byte(input logic [7:0] p, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (!p[i]) lvl = ~lvl;
      bit_period(lvl, p[i], $sformatf("%s bit%0d", tag, i));
    end
  endtask

  // Park the line at level s and strobe so the reference equals s.
  task automatic set_ref(input logic s);
    lvl = s;
    d_plus = s;
    ticks(4);
    shift_enable = 1'b1;
    ticks(1);
    shift_enable = 1'b0;
    ticks(3);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    ticks(2);
    n_rst = 1'b1;
    ticks(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lvl = 1'b1;
    n_rst = 1'b0;
    d_plus = 1'b0;
    shift_enable = 1'b0;
    eop = 1'b0;

    // Reset state.
    #1;
    check(d_orig, 1'b1, "reset_value");
    ticks(2);
    n_rst = 1'b1;

    // Line held at 0 after reset: first strobe sees cur 0 against idle 1.
    bit_period(1'b0, 1'b0, "first_strobe_vs_idle");
    lvl = 1'b0;
    send_byte(8'b1000_0000, "b80_from0");

    // Payloads from idle level 1.
    set_ref(1'b1);
    send_byte(8'b0000_0001, "b01_from1");
    set_ref(1'b1);
    send_byte(8'b1010_1010, "bAA_from1");
    set_ref(1'b1);
    send_byte(8'b0101_0101, "b55_from1");

    // All ones and all zeros from both starting levels.
    set_ref(1'b0);
    send_byte(8'hFF, "bFF_from0");
    set_ref(1'b1);
    send_byte(8'hFF, "bFF_from1");
    set_ref(1'b0);
    send_byte(8'h00, "b00_from0");
    set_ref(1'b1);
    send_byte(8'h00, "b00_from1");

    // EOP forces the reference to 1 rather than loading the line.
    do_reset();
    eop = 1'b1;
    d_plus = 1'b0;
    ticks(4);
    check(d_orig, 1'b0, "eop_strobe_cur0_prev1");
    shift_enable = 1'b1;
    ticks(1);
    shift_enable = 1'b0;
    check(d_orig, 1'b0, "eop_after_strobe_prev_forced");
    eop = 1'b0;
    ticks(3);
    bit_period(1'b1, 1'b1, "eop_next_bit_vs_idle");

    // Reset mid-byte with the line at 0 is immediate and clears history.
    set_ref(1'b1);
    d_plus = 1'b0;
    ticks(2);
    check(d_orig, 1'b0, "pre_reset_toggle_seen");
    #2;
    n_rst = 1'b0;
    #1;
    check(d_orig, 1'b1, "async_reset_immediate");
    ticks(2);
    n_rst = 1'b1;
    check(d_orig, 1'b1, "reset_release_before_edge");
    ticks(1);
    check(d_orig, 1'b0, "reset_release_one_clock");

    // Hold: no strobe means no reference update, even with eop pulsed.
    set_ref(1'b1);
    d_plus = 1'b0;
    eop = 1'b1;
    ticks(1);
    eop = 1'b0;
    ticks(1);
    check(d_orig, 1'b0, "hold_prev_after_eop_pulse");
    d_plus = 1'b1;
    ticks(1);
    check(d_orig, 1'b1, "hold_line_back_to_ref");
    ticks(2);
    check(d_orig, 1'b1, "hold_net_same_at_strobe");
    shift_enable = 1'b1;
    ticks(1);
    shift_enable = 1'b0;
    ticks(3);

    // Hold with net change: ref 0, line 1 -> 0 -> 1 without a strobe.
    set_ref(1'b0);
    d_plus = 1'b1;
    ticks(1);
    eop = 1'b1;
    d_plus = 1'b0;
    ticks(1);
    eop = 1'b0;
    d_plus = 1'b1;
    ticks(2);
    check(d_orig, 1'b0, "hold_net_toggle_at_strobe");

    // Latency: a line change is invisible until the next rising edge.
    set_ref(1'b1);
    d_plus = 1'b0;
    #1;
    check(d_orig, 1'b1, "latency_before_edge");
    ticks(1);
    check(d_orig, 1'b0, "latency_after_edge");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

NRZI decoder for the USB receiver data path. It samples the raw `d_plus` line every clock and keeps a copy of the line level from the previous bit period. On each bit-centre strobe it emits the decoded bit: 1 when the line did not change since the previous bit, 0 when it toggled. It sits between the edge-detect/timer block, which supplies `shift_enable` and `eop`, and the receive shift register, which samples `d_orig` on `shift_enable`.

## Interface
Parameters: none.

- `clk`  input  1  system clock (96 MHz nominal, about 8 clocks per USB bit)
- `n_rst`  input  1  asynchronous, active-low reset
- `d_plus`  input  1  raw D+ line level, NRZI encoded, idle level 1
- `shift_enable`  input  1  one-cycle bit-centre strobe from the timer; at most one pulse per bit period
- `eop`  input  1  end-of-packet detected; qualifies the `shift_enable` update
- `d_orig`  output  1  decoded (NRZ) bit; valid when `shift_enable` is high

## Operation
- Two state flops:
  - `cur_bit`: current line sample.
  - `prev_bit`: line level at the last bit-centre strobe.
- `cur_bit` loads `d_plus` on every rising `clk`, regardless of `shift_enable` or `eop`.
- `prev_bit` update on rising `clk`:
  - `shift_enable`=1 and `eop`=0: `prev_bit` <= `d_plus`, the same value `cur_bit` is loading.
  - `shift_enable`=1 and `eop`=1: `prev_bit` <= 1. This forces the idle/J reference so the next packet's first bit decodes against idle.
  - `shift_enable`=0: `prev_bit` holds, whatever the value of `eop`.
- `d_orig` = XNOR(`cur_bit`, `prev_bit`), combinational from the flops only.
  - No combinational path from `d_plus`, `shift_enable` or `eop` to `d_orig`.
  - Same level gives 1; toggle gives 0.
- `eop` without `shift_enable` has no effect.
- Reset (`n_rst`=0, asynchronous):
  - `cur_bit` = 1 and `prev_bit` = 1, so `d_orig` = 1.
  - Reset asserted mid-packet discards history immediately.
  - Decoding after release compares against idle level 1.
- No other state, counters or FSM. The block is a pure two-register datapath.

## Timing
- Latency from a `d_plus` change to its effect on `d_orig` is 1 clock: the change is visible after the next rising edge.
- `d_orig` for bit n is stable from 1 clock after the line settles until the rising edge that consumes `shift_enable`.
- The timer asserts `shift_enable` at least 2 clocks after a line transition. This is satisfied by the mid-bit strobe at about 4 clocks.
- On the strobe edge, `prev_bit` takes the new reference. `d_orig` therefore reads 1 on the following cycle, until the line next toggles.
- The value of `d_orig` sampled by downstream logic is the value present during the cycle `shift_enable` is high, before the edge.
- `d_plus` is synchronous to `clk`; the upstream synchronizer provides this.

## Test plan
- Reset, hold `d_plus`=0, strobe once, then send NRZI of 8'b10000000 LSB first at 8 clocks/bit with the strobe at clock 4 of each bit -> `d_orig` at each strobe = 0,0,0,0,0,0,0,1.
- Same framing, initial line level 1, payloads 8'b00000001, 8'b10101010, 8'b01010101 -> `d_orig` at each strobe equals the payload bit, LSB first.
- All ones, 8'hFF: line held constant -> `d_orig`=1 at all 8 strobes. All zeros, 8'h00: line toggles every bit -> `d_orig`=0 at all 8 strobes. Run both with starting level 0 and with starting level 1.
- EOP reference force: reset, `eop`=1, `d_plus`=0 -> at the strobe `d_orig`=0 (cur 0, prev 1). Then set `eop`=0 and `d_plus`=1 -> at the next strobe `d_orig`=1, which proves `prev_bit` was forced to 1, not loaded with 0.
- Reset behaviour: assert `n_rst` mid-byte with the line at 0 -> `d_orig`=1 immediately, without a clock edge. After release with `d_plus`=0 -> `d_orig`=0 one clock later.
- Hold behaviour: toggle `d_plus` twice between strobes with `shift_enable`=0 and `eop` pulsed -> `prev_bit` unchanged. `d_orig` at the strobe reflects only the net level against the last strobe.
